keypad_decoder: RTL and testbench

Column-side reader for the 4x4 matrix keypad. Samples the active-low column lines against the active-low row select driven by the row scanner, synchronizes and debounces the press, and emits one registered 4-bit key code with a single-cycle valid strobe per press. While a key is being qualified or held, it asserts `scan_hold` so the scanner freezes on the pressed row. It sits between the keypad pins and the seven-segment display logic.

---
 rtl/keypad_decoder.sv | 166 ++++++++++++++++
 tb/tb_keypad_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_decoder.sv
// keypad_decoder: column-side reader for a 4x4 active-low matrix keypad.
// Synchronizes column pins and the matching row select, debounces press and
// release, and emits a registered key code with a one-cycle valid strobe.
// Optional: define KEYPAD_MULTIKEY_REJECT_EN to refuse multi-column presses
// (otherwise the lowest-index low column wins).
module keypad_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] r_sel,
    input  logic [3:0] c_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       scan_hold
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nx;
    logic [3:0]       c_s1, c_s2, r_s1, r_s2;
    logic [1:0]       row_q, col_q, row_nx, col_nx;
    logic [1:0]       hit_row, hit_col;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0]       code_nx;
    logic             valid_nx, held_nx;
    logic             row_ok, hit, col_low, row_match, multi_bad;

    // Two-flop synchronizers; rows are delayed identically so each column
    // sample stays paired with the row that produced it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_s1 <= 4'hF;
            c_s2 <= 4'hF;
            r_s1 <= 4'hF;
            r_s2 <= 4'hF;
        end else begin
            c_s1 <= c_in;
            c_s2 <= c_s1;
            r_s1 <= r_sel;
            r_s2 <= r_s1;
        end
    end

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    assign multi_bad = ($countones(~c_s2) > 1);
`else
    assign multi_bad = 1'b0;
`endif

    // Row decode (only one-hot-low counts) and lowest-index column priority.
    always_comb begin
        row_ok  = 1'b1;
        hit_row = 2'd0;
        case (r_s2)
            4'b1110: hit_row = 2'd0;
            4'b1101: hit_row = 2'd1;
            4'b1011: hit_row = 2'd2;
            4'b0111: hit_row = 2'd3;
            default: row_ok = 1'b0;
        endcase
        if (!c_s2[0])      hit_col = 2'd0;
        else if (!c_s2[1]) hit_col = 2'd1;
        else if (!c_s2[2]) hit_col = 2'd2;
        else               hit_col = 2'd3;
    end

    assign hit       = row_ok && (c_s2 != 4'hF) && !multi_bad;
    assign col_low   = !c_s2[col_q];
    assign row_match = row_ok && (hit_row == row_q);
    assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_ONE;
    assign scan_hold = (state != IDLE);

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    // State, captured key position, debounce counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nx;
            row_q     <= row_nx;
            col_q     <= col_nx;
            cnt       <= cnt_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_held  <= held_nx;
        end
    end

    // Next-state: qualify a press for DEBOUNCE_CYCLES samples, then a release.
    always_comb begin
        state_nx = state;
        row_nx   = row_q;
        col_nx   = col_q;
        cnt_nx   = cnt;
        code_nx  = key_code;
        valid_nx = 1'b0;
        held_nx  = key_held;
        case (state)
            IDLE: begin
                if (hit) begin
                    row_nx   = hit_row;
                    col_nx   = hit_col;
                    cnt_nx   = CNT_ONE;
                    state_nx = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (col_low && row_match && !multi_bad) begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc >= DB_LIM) begin
                        code_nx  = key_map(row_q, col_q);
                        valid_nx = 1'b1;
                        held_nx  = 1'b1;
                        state_nx = PRESSED;
                    end
                end else begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            PRESSED: begin
                if (!col_low) begin
                    cnt_nx   = CNT_ONE;
                    state_nx = RELEASE;
                end
            end
            default: begin
                if (col_low) begin
                    cnt_nx   = '0;
                    state_nx = PRESSED;
                end else if (cnt_inc >= DB_LIM) begin
                    cnt_nx   = '0;
                    held_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder: directed test-plan scenarios with literal
// expectations, then a randomized scanner/keypad run, all checked every
// cycle against a run-length behavioural model of press/release debouncing.
module tb_keypad_decoder;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] r_sel = 4'hF;
    logic [3:0] c_in = 4'hF;
    logic [3:0] key_code;
    logic       key_valid, key_held, scan_hold;

    int errors = 0;
    int checks = 0;
    int strobes = 0;

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    localparam bit REJ = 1'b1;
`else
    localparam bit REJ = 1'b0;
`endif

    keypad_decoder #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .r_sel(r_sel), .c_in(c_in),
        .key_code(key_code), .key_valid(key_valid),
        .key_held(key_held), .scan_hold(scan_hold)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0] hc [2] = '{4'hF, 4'hF};
    logic [3:0] hr [2] = '{4'hF, 4'hF};
    bit   m_cand = 0, m_held = 0, m_valid = 0;
    int   m_run = 0, m_rel = 0, m_row = 0, m_col = 0;
    logic [3:0] m_code = 4'h0;

    function automatic int row_of(input logic [3:0] r);
        int idx = -1;
        if ($countones(~r) == 1)
            for (int i = 0; i < 4; i++) if (!r[i]) idx = i;
        return idx;
    endfunction

    function automatic int col_of(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) if (!c[i]) return i;
        return -1;
    endfunction

    function automatic int lowest_col(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (!c[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hc[0] = 4'hF; hc[1] = 4'hF; hr[0] = 4'hF; hr[1] = 4'hF;
        m_cand = 0; m_held = 0; m_valid = 0; m_run = 0; m_rel = 0;
        m_code = 4'h0;
    endtask

    task automatic model_step();
        logic [3:0] c, r;
        int rowi, ncol;
        bit ok;
        c = hc[1]; r = hr[1];
        hc[1] = hc[0]; hc[0] = c_in;
        hr[1] = hr[0]; hr[0] = r_sel;
        rowi = row_of(r);
        ncol = $countones(~c);
        ok = !(REJ && ncol > 1);
        m_valid = 0;
        if (m_held) begin
            if (c[m_col]) begin
                if (m_rel == 0) m_rel = 1;
                else begin
                    m_rel++;
                    if (m_rel >= D) begin m_held = 0; m_rel = 0; end
                end
            end else m_rel = 0;
        end else if (m_cand) begin
            if (!c[m_col] && rowi == m_row && ok) begin
                m_run++;
                if (m_run >= D) begin
                    m_valid = 1; m_held = 1; m_cand = 0; m_rel = 0;
                    m_code = kmap[m_row*4 + m_col];
                end
            end else m_cand = 0;
        end else if (rowi >= 0 && c != 4'hF && ok) begin
            m_cand = 1; m_row = rowi; m_col = lowest_col(c); m_run = 1;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("key_code", key_code, m_code);
        chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        chk("key_held", {3'b0, key_held}, {3'b0, m_held});
        chk("scan_hold", {3'b0, scan_hold}, {3'b0, (m_cand || m_held)});
        if (key_valid === 1'b1) strobes++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic settle();
        c_in = 4'hF;
        tick(12);
    endtask

    int s0, row_ptr, dur, krow, kcol, kcol2;
    bit pressed, multi;
    logic [3:0] one;

    initial begin
        // reset state
        tick(3);
        chk("rst_code", key_code, 4'h0);
        chk("rst_flags", {1'b0, key_valid, key_held, scan_hold}, 4'h0);
        reset = 1'b1;
        tick(2);

        // r1/c2 press -> key 6 at edge 6, scan_hold from edge 3
        r_sel = 4'b1101; c_in = 4'b1011;
        tick(2);
        chk("p6_hold_e2", {3'b0, scan_hold}, 4'h0);
        tick(1);
        chk("p6_hold_e3", {3'b0, scan_hold}, 4'h1);
        tick(2);
        chk("p6_valid_e5", {3'b0, key_valid}, 4'h0);
        tick(1);
        chk("p6_valid_e6", {3'b0, key_valid}, 4'h1);
        chk("p6_code", key_code, 4'h6);
        chk("p6_held", {3'b0, key_held}, 4'h1);
        tick(1);
        chk("p6_pulse_end", {3'b0, key_valid}, 4'h0);
        settle();

        // bounce on key 1, then stable low
        r_sel = 4'b1110;
        s0 = strobes;
        for (int i = 0; i < 10; i++) begin
            c_in = (i % 2) ? 4'hF : 4'b1110;
            tick(1);
        end
        c_in = 4'b1110;
        tick(D + 1);
        chki("bounce_nostrobe", strobes - s0, 0);
        tick(1);
        chk("bounce_valid", {3'b0, key_valid}, 4'h1);
        chk("bounce_code", key_code, 4'h1);
        settle();

        // release glitch on key 5
        r_sel = 4'b1101; c_in = 4'b1101;
        tick(D + 2);
        chk("rel_code", key_code, 4'h5);
        tick(3);
        s0 = strobes;
        c_in = 4'hF; tick(2);
        c_in = 4'b1101; tick(5);
        chk("rel_glitch_held", {3'b0, key_held}, 4'h1);
        c_in = 4'hF;
        tick(D + 1);
        chk("rel_held_e5", {3'b0, key_held}, 4'h1);
        tick(1);
        chk("rel_held_e6", {3'b0, key_held}, 4'h0);
        chk("rel_scan_hold", {3'b0, scan_hold}, 4'h0);
        chki("rel_nostrobe", strobes - s0, 0);
        settle();

        // two columns on row 3
        r_sel = 4'b0111; c_in = 4'b0110;
        s0 = strobes;
        tick(D + 2);
        if (REJ) begin
            chki("multi_nostrobe", strobes - s0, 0);
            chk("multi_idle", {3'b0, scan_hold}, 4'h0);
        end else begin
            chk("multi_valid", {3'b0, key_valid}, 4'h1);
            chk("multi_code", key_code, 4'hE);
        end
        settle();

        // reset during PRESSED with key 9
        r_sel = 4'b1011; c_in = 4'b1011;
        tick(D + 2);
        chk("r9_code", key_code, 4'h9);
        tick(2);
        #2 reset = 1'b0;
        #1;
        chk("r9_async_code", key_code, 4'h0);
        chk("r9_async_flags", {1'b0, key_valid, key_held, scan_hold}, 4'h0);
        tick(1);
        reset = 1'b1;
        tick(D + 1);
        chk("r9_pre_valid", {3'b0, key_valid}, 4'h0);
        tick(1);
        chk("r9_revalid", {3'b0, key_valid}, 4'h1);
        chk("r9_recode", key_code, 4'h9);
        settle();

        // no row selected: never a hit
        r_sel = 4'hF; c_in = 4'h0;
        s0 = strobes;
        tick(8);
        chk("norow_scan_hold", {3'b0, scan_hold}, 4'h0);
        chki("norow_nostrobe", strobes - s0, 0);
        settle();

        // randomized scanner + keypad
        row_ptr = 0; dur = 0; pressed = 0; multi = 0;
        krow = 0; kcol = 0; kcol2 = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (dur == 0) begin
                pressed = ($urandom % 3) != 0;
                multi   = ($urandom % 6) == 0;
                krow    = $urandom % 4;
                kcol    = $urandom % 4;
                kcol2   = $urandom % 4;
                dur     = $urandom_range(2, 30);
            end
            dur--;
            if (!scan_hold) row_ptr = (row_ptr + 1) % 4;
            one = 4'b0001 << row_ptr;
            r_sel = ~one;
            if (!scan_hold && ($urandom % 40) == 0) r_sel = 4'hF;
            c_in = 4'hF;
            if (pressed && row_of(r_sel) == krow) begin
                c_in[kcol] = 1'b0;
                if (multi) c_in[kcol2] = 1'b0;
            end
            if (($urandom % 12) == 0) c_in = 4'hF;
            tick(1);
        end
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
